// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t       : FSM encoding (IDLE=00, RUN=01, DONE=10)
//   DEFAULT_WIDTH : default operand width
//   cnt_w()       : bit-counter width for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half-adder cells.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit
//   co        : carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  ha u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  ha u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  // At most one of the two half-adder carries can be set, so OR suffices.
  assign co = c1 | c2;

endmodule

// File: rtl/ha.sv
// Half-adder cell.
// Ports:
//   a, b : input bits
//   s    : sum (a ^ b)
//   c    : carry (a & b)
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial, LSB-first adder: {carry_out, sum_out} = a_in + b_in + cin_in.
// One operand bit pair is added per clock through a single full-adder cell.
// Optional macro SERIAL_ADD_OVF_EN adds ovf_out (signed overflow flag).
// Ports:
//   clk_in    : clock, rising edge
//   rst_in    : asynchronous active-high reset
//   start_in  : request an addition (sampled only in IDLE)
//   a_in/b_in : operands, captured on the accepted start edge
//   cin_in    : carry-in, captured on the accepted start edge
//   busy_out  : high in RUN and DONE
//   done_out  : one-cycle result-valid pulse
//   sum_out   : registered sum, held until the next result
//   carry_out : registered final carry, held until the next result
//   ovf_out   : (SERIAL_ADD_OVF_EN only) registered two's-complement overflow
module serial_adder_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf_out,
`endif
  output logic             carry_out
);

  localparam int CW = cnt_w(WIDTH);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] psum_reg;
  logic [WIDTH-1:0] psum_next;
  logic [CW-1:0]    count_reg;
  logic             c_q_reg;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder_cell u_fa (
    .a  (a_sr_reg[0]),
    .b  (b_sr_reg[0]),
    .cin(c_q_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  assign psum_next = {fa_s, psum_reg[WIDTH-1:1]};
  assign last_bit  = (count_reg == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state_reg;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_in) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy_out = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy_out   = 1'b1;
        done_out   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand shifters, carry flop, partial sum and result registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      psum_reg  <= '0;
      count_reg <= '0;
      c_q_reg   <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_in) begin
            a_sr_reg  <= a_in;
            b_sr_reg  <= b_in;
            c_q_reg   <= cin_in;
            psum_reg  <= '0;
            count_reg <= '0;
          end
        end
        ST_RUN: begin
          a_sr_reg  <= a_sr_reg >> 1;
          b_sr_reg  <= b_sr_reg >> 1;
          c_q_reg   <= fa_co;
          psum_reg  <= psum_next;
          count_reg <= count_reg + CW'(1);
          if (last_bit) begin
            sum_out   <= psum_next;
            carry_out <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // On the MSB step c_q_reg is the carry into the MSB.
            ovf_out   <= c_q_reg ^ fa_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;

  localparam int WIDTH = 8;

  logic             clk_in;
  logic             rst_in;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_out;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .sum_out  (sum_out),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_out  (ovf_out),
`endif
    .carry_out(carry_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Issue a start, scramble the inputs after capture, and wait for done.
  // lat = number of edges after the start edge at which done_out was seen,
  // or -1 if it never appeared within the budget.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output int lat);
    lat = -1;
    @(negedge clk_in);
    a_in = a; b_in = b; cin_in = cin; start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    a_in = 8'hC3; b_in = 8'h3C; cin_in = ~cin;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (done_out === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b0; start_in = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    #1 rst_in = 1'b1;
    #3;
    checks++;
    if ({busy_out, done_out, sum_out, carry_out} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h carry=%b, want all 0",
               busy_out, done_out, sum_out, carry_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int seen_done;
    int busy_bad;
    @(negedge clk_in);
    a_in = 8'h5A; b_in = 8'h33; cin_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0; a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
    seen_done = -1;
    busy_bad  = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (k <= 8 && busy_out !== 1'b1) busy_bad++;
      if (k == 9 && busy_out !== 1'b0) busy_bad++;
      if (done_out === 1'b1) begin
        if (seen_done == -1) seen_done = k;
        else seen_done = 100;
      end
    end
    checks++;
    if (seen_done !== 8) begin
      errors++;
      $display("FAIL basic_latency: done edge=%0d want 8 (100=multiple)", seen_done);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL basic_busy: %0d wrong busy samples, want 0", busy_bad);
    end
    checks++;
    if ({carry_out, sum_out} !== 9'h08D) begin
      errors++;
      $display("FAIL basic_sum: got c=%b s=%h want c=0 s=8d", carry_out, sum_out);
    end
    repeat (3) @(negedge clk_in);
    checks++;
    if ({carry_out, sum_out} !== 9'h08D) begin
      errors++;
      $display("FAIL basic_hold: got c=%b s=%h want c=0 s=8d", carry_out, sum_out);
    end
    $display("test_basic 5a+33+0 -> c=%b s=%h at edge %0d", carry_out, sum_out, seen_done);
  endtask

  task automatic test_vectors;
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic [8:0] vexp [5];
    logic       vovf [5];
    int lat;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; vexp[0] = 9'h100; vovf[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1; vexp[1] = 9'h1FF; vovf[1] = 1'b0;
    va[2] = 8'h7F; vb[2] = 8'h01; vc[2] = 1'b0; vexp[2] = 9'h080; vovf[2] = 1'b1;
    va[3] = 8'h80; vb[3] = 8'h80; vc[3] = 1'b0; vexp[3] = 9'h100; vovf[3] = 1'b1;
    va[4] = 8'hAA; vb[4] = 8'h55; vc[4] = 1'b1; vexp[4] = 9'h100; vovf[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_add(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL vec%0d_latency: done edge=%0d want 8", i, lat);
      end
      checks++;
      if ({carry_out, sum_out} !== vexp[i]) begin
        errors++;
        $display("FAIL vec%0d_sum: got %h want %h", i, {carry_out, sum_out}, vexp[i]);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ovf_out !== vovf[i]) begin
        errors++;
        $display("FAIL vec%0d_ovf: got %b want %b", i, ovf_out, vovf[i]);
      end
`endif
      $display("test_vectors %h+%h+%b -> c=%b s=%h ovf_exp=%b", va[i], vb[i], vc[i],
               carry_out, sum_out, vovf[i]);
    end
  endtask

  task automatic test_busy_ignore;
    int n_done;
    int lat;
    @(negedge clk_in);
    a_in = 8'h10; b_in = 8'h20; cin_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        a_in = 8'hAA; b_in = 8'h55; start_in = 1'b1;
      end
      @(posedge clk_in);
      #1 start_in = 1'b0;
      @(negedge clk_in);
      if (done_out === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL busy_single_done: got %0d done pulses want 1", n_done);
    end
    checks++;
    if ({carry_out, sum_out} !== 9'h030) begin
      errors++;
      $display("FAIL busy_sum: got %h want 030", {carry_out, sum_out});
    end
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL busy_back_idle: busy=%b want 0", busy_out);
    end
    do_add(8'h01, 8'h02, 1'b0, lat);
    checks++;
    if (lat !== 8 || {carry_out, sum_out} !== 9'h003) begin
      errors++;
      $display("FAIL busy_restart: lat=%0d sum=%h want lat=8 sum=003", lat, {carry_out, sum_out});
    end
    $display("test_busy_ignore done pulses=%0d s=%h", n_done, sum_out);
  endtask

  task automatic test_reset_mid;
    int n_done;
    int lat;
    @(negedge clk_in);
    a_in = 8'h5A; b_in = 8'h33; cin_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({busy_out, done_out, sum_out, carry_out} !== 11'b0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b done=%b sum=%h carry=%b want all 0",
               busy_out, done_out, sum_out, carry_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_in);
      if (done_out === 1'b1 || busy_out === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: %0d busy/done samples want 0", n_done);
    end
    do_add(8'h01, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 8 || {carry_out, sum_out} !== 9'h002) begin
      errors++;
      $display("FAIL midreset_recover: lat=%0d sum=%h want lat=8 sum=002", lat, {carry_out, sum_out});
    end
    $display("test_reset_mid recover s=%h", sum_out);
  endtask

  task automatic test_back_to_back;
    int lat;
    // Start again on the cycle right after done: IDLE accepts immediately.
    do_add(8'h12, 8'h34, 1'b1, lat);
    checks++;
    if (lat !== 8 || {carry_out, sum_out} !== 9'h047) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d sum=%h want lat=8 sum=047", lat, {carry_out, sum_out});
    end
    do_add(8'hF0, 8'h0F, 1'b1, lat);
    checks++;
    if (lat !== 8 || {carry_out, sum_out} !== 9'h100) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d sum=%h want lat=8 sum=100", lat, {carry_out, sum_out});
    end
    $display("test_back_to_back last c=%b s=%h", carry_out, sum_out);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
